// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses the master modport; the controller uses the slave modport.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_Rs1;
    logic [4:0]       IF_ID_Rs2;
    logic             IF_ID_UseRs1;
    logic             IF_ID_UseRs2;
    logic [4:0]       ID_EX_Rd;
    logic             ID_EX_MemRead;
    logic             ID_EX_MulDiv;
    logic             branch_taken_i;
    logic             md_done_i;
    logic             md_start_o;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_hold_o;
    logic             id_ex_bubble_o;
    logic             ex_mem_bubble_o;
    logic [CNT_W-1:0] stall_cycles_o;

    modport master (
        output IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2,
        output ID_EX_Rd, ID_EX_MemRead, ID_EX_MulDiv,
        output branch_taken_i, md_done_i,
        input  md_start_o, pc_write_o, if_id_write_o, if_id_flush_o,
        input  id_ex_hold_o, id_ex_bubble_o, ex_mem_bubble_o, stall_cycles_o
    );

    modport slave (
        input  IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2,
        input  ID_EX_Rd, ID_EX_MemRead, ID_EX_MulDiv,
        input  branch_taken_i, md_done_i,
        output md_start_o, pc_write_o, if_id_write_o, if_id_flush_o,
        output id_ex_hold_o, id_ex_bubble_o, ex_mem_bubble_o, stall_cycles_o
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing for the 5-stage core: load-use stalls, taken-branch flushes,
// mul/div start/done handshake, and a saturating count of stalled cycles.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_controller_if.slave hz
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    logic md_start;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_bubble;
    logic ex_mem_bubble;

    // x0 never carries a real dependency, so a load to x0 never stalls.
    assign rs1_hit  = hz.IF_ID_UseRs1 && (hz.IF_ID_Rs1 == hz.ID_EX_Rd);
    assign rs2_hit  = hz.IF_ID_UseRs2 && (hz.IF_ID_Rs2 == hz.ID_EX_Rd);
    assign load_use = hz.ID_EX_MemRead && (hz.ID_EX_Rd != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        state_next    = state_reg;
        md_start      = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;

        case (state_reg)
            RUN: begin
                if (hz.ID_EX_MulDiv) begin
                    md_start      = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                    state_next    = MD_BUSY;
                end else if (load_use) begin
                    // A branch seen during this stall is re-resolved next cycle with forwarded data.
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_bubble  = 1'b1;
                end else if (hz.branch_taken_i) begin
                    if_id_flush   = 1'b1;
                end
            end
            MD_BUSY: begin
                // On done the pipeline advances; any other hazard is left for RUN to re-evaluate.
                if (hz.md_done_i) begin
                    state_next    = RUN;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_hold    = 1'b1;
                    ex_mem_bubble = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!pc_write && !(&stall_cnt_reg)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= RUN;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign hz.md_start_o      = md_start;
    assign hz.pc_write_o      = pc_write;
    assign hz.if_id_write_o   = if_id_write;
    assign hz.if_id_flush_o   = if_id_flush;
    assign hz.id_ex_hold_o    = id_ex_hold;
    assign hz.id_ex_bubble_o  = id_ex_bubble;
    assign hz.ex_mem_bubble_o = ex_mem_bubble;
    assign hz.stall_cycles_o  = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: directed hazard scenarios plus random traffic, compared against
// a rule-level reference model; a 4-bit-counter instance shares the stimulus for saturation.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memrd, muldiv, br, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: whether a mul/div is outstanding, and total stalled cycles.
    bit busy_m;
    int stall_total;

    localparam logic [6:0] C_DEF  = 7'b0110000; // {start,pc_w,ifid_w,flush,hold,bubble,exmem_bubble}
    localparam logic [6:0] C_MDST = 7'b1000101;
    localparam logic [6:0] C_MDHD = 7'b0000101;
    localparam logic [6:0] C_LU   = 7'b0000010;
    localparam logic [6:0] C_BR   = 7'b0111000;

    hazard_controller_if #(.CNT_W(16)) hz ();
    hazard_controller_if #(.CNT_W(4))  hz_sat ();

    always #5 clk = ~clk;

    assign hz.IF_ID_Rs1      = rs1;    assign hz_sat.IF_ID_Rs1      = rs1;
    assign hz.IF_ID_Rs2      = rs2;    assign hz_sat.IF_ID_Rs2      = rs2;
    assign hz.IF_ID_UseRs1   = use1;   assign hz_sat.IF_ID_UseRs1   = use1;
    assign hz.IF_ID_UseRs2   = use2;   assign hz_sat.IF_ID_UseRs2   = use2;
    assign hz.ID_EX_Rd       = rd;     assign hz_sat.ID_EX_Rd       = rd;
    assign hz.ID_EX_MemRead  = memrd;  assign hz_sat.ID_EX_MemRead  = memrd;
    assign hz.ID_EX_MulDiv   = muldiv; assign hz_sat.ID_EX_MulDiv   = muldiv;
    assign hz.branch_taken_i = br;     assign hz_sat.branch_taken_i = br;
    assign hz.md_done_i      = done;   assign hz_sat.md_done_i      = done;

    hazard_controller #(.CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    hazard_controller #(.CNT_W(4)) dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz_sat)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_ctrl();
        bit hit;
        if (busy_m) return done ? C_DEF : C_MDHD;
        if (muldiv) return C_MDST;
        hit = (use1 && rs1 == rd) || (use2 && rs2 == rd);
        if (memrd && rd != 5'd0 && hit) return C_LU;
        if (br) return C_BR;
        return C_DEF;
    endfunction

    function automatic int sat_cnt(input int w);
        int mx;
        mx = (1 << w) - 1;
        return (stall_total > mx) ? mx : stall_total;
    endfunction

    function automatic logic [6:0] ctrl_main();
        return {hz.md_start_o, hz.pc_write_o, hz.if_id_write_o, hz.if_id_flush_o,
                hz.id_ex_hold_o, hz.id_ex_bubble_o, hz.ex_mem_bubble_o};
    endfunction

    function automatic logic [6:0] ctrl_sat();
        return {hz_sat.md_start_o, hz_sat.pc_write_o, hz_sat.if_id_write_o, hz_sat.if_id_flush_o,
                hz_sat.id_ex_hold_o, hz_sat.id_ex_bubble_o, hz_sat.ex_mem_bubble_o};
    endfunction

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; memrd = 1'b0; muldiv = 1'b0; br = 1'b0; done = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1;
    endtask

    // One pipeline cycle: check combinational outputs mid-cycle, then advance the model on the edge.
    task automatic do_cycle(input string tag);
        logic [6:0] e;
        @(negedge clk);
        e = exp_ctrl();
        check_eq({tag, "_ctrl"}, {25'd0, ctrl_main()}, {25'd0, e});
        check_eq({tag, "_ctrl4"}, {25'd0, ctrl_sat()}, {25'd0, e});
        check_eq({tag, "_cnt"}, {16'd0, hz.stall_cycles_o}, sat_cnt(16));
        check_eq({tag, "_cnt4"}, {28'd0, hz_sat.stall_cycles_o}, sat_cnt(4));
        $display("cyc %0d %s ctrl=%b cnt=%0d cnt4=%0d", cyc, tag, ctrl_main(),
                 hz.stall_cycles_o, hz_sat.stall_cycles_o);
        @(posedge clk);
        if (!e[5]) stall_total++;
        busy_m = busy_m ? !done : muldiv;
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        busy_m = 1'b0;
        stall_total = 0;

        #3;
        check_eq("reset_ctrl", {25'd0, ctrl_main()}, {25'd0, C_DEF});
        check_eq("reset_cnt", {16'd0, hz.stall_cycles_o}, 32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Load-use stall, then counter moves 0 -> 1.
        set_load_use();   do_cycle("load_use");
        set_idle();       do_cycle("after_lu");
        check_eq("lu_cnt_is_1", {16'd0, hz.stall_cycles_o}, 32'd1);

        // No false stall: dependency not read, or load to x0.
        set_load_use(); use2 = 1'b0;          do_cycle("no_use");
        set_load_use(); rd = 5'd0; rs2 = 5'd0; do_cycle("rd_zero");
        set_load_use(); use2 = 1'b0; use1 = 1'b1; rs1 = 5'd5; do_cycle("lu_rs1");

        // Mul/div: start, two busy cycles (one with a branch), done, back-to-back start, instant done.
        set_idle(); muldiv = 1'b1; done = 1'b1;   do_cycle("md_start");
        done = 1'b0;                              do_cycle("md_busy1");
        br = 1'b1;                                do_cycle("md_busy_br");
        br = 1'b0; done = 1'b1;                   do_cycle("md_done");
        done = 1'b0;                              do_cycle("md_restart");
        done = 1'b1; memrd = 1'b1; rd = 5'd3; rs1 = 5'd3; use1 = 1'b1; do_cycle("md_done0");
        set_idle();                               do_cycle("md_after");

        // Branch alone, branch under load-use, mul/div beats load.
        set_idle(); br = 1'b1;                    do_cycle("branch");
        set_load_use(); br = 1'b1;                do_cycle("branch_lu");
        set_load_use(); muldiv = 1'b1;            do_cycle("md_over_lu");
        set_idle(); muldiv = 1'b1;                do_cycle("md_busy_a");

        // Asynchronous reset while busy.
        #1 rst = 1'b1; set_idle();
        #1;
        check_eq("rst_mid_ctrl", {25'd0, ctrl_main()}, {25'd0, C_DEF});
        check_eq("rst_mid_cnt", {16'd0, hz.stall_cycles_o}, 32'd0);
        check_eq("rst_mid_cnt4", {28'd0, hz_sat.stall_cycles_o}, 32'd0);
        busy_m = 1'b0; stall_total = 0;
        #1 rst = 1'b0;
        muldiv = 1'b1;                            do_cycle("md_fresh");
        done = 1'b1;                              do_cycle("md_fresh_done");

        // Saturation of the 4-bit counter after 20 stalls.
        for (int i = 0; i < 20; i++) begin
            set_load_use();                       do_cycle("sat_stall");
        end
        set_idle();                               do_cycle("sat_idle");
        check_eq("sat_hold15", {28'd0, hz_sat.stall_cycles_o}, 32'd15);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rs1    = 5'($urandom_range(0, 7));
            rs2    = 5'($urandom_range(0, 7));
            rd     = 5'($urandom_range(0, 7));
            use1   = 1'($urandom_range(0, 1));
            use2   = 1'($urandom_range(0, 1));
            memrd  = 1'($urandom_range(0, 1));
            muldiv = ($urandom_range(0, 7) == 0);
            br     = ($urandom_range(0, 3) == 0);
            done   = ($urandom_range(0, 2) == 0);
            do_cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing block for the 5-stage RISC-V core. Decides each cycle whether the PC and IF/ID register advance, hold, or flush. Inserts bubbles into ID/EX and EX/MEM. Runs the start/done handshake with the multi-cycle multiply/divide unit in EX. Sits beside the forwarding logic and covers the hazards forwarding cannot: load-use, taken branch in ID, and multi-cycle EX. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- IF_ID_Rs1  input  5  rs1 field of the instruction in ID
- IF_ID_Rs2  input  5  rs2 field of the instruction in ID
- IF_ID_UseRs1  input  1  instruction in ID reads rs1
- IF_ID_UseRs2  input  1  instruction in ID reads rs2
- ID_EX_Rd  input  5  destination of the instruction in EX
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_MulDiv  input  1  instruction in EX is a multi-cycle mul/div
- branch_taken_i  input  1  branch/jump resolved taken in ID
- md_done_i  input  1  mul/div result valid this cycle
- md_start_o  output  1  one-cycle start pulse to the mul/div unit
- pc_write_o  output  1  PC register enable
- if_id_write_o  output  1  IF/ID register enable
- if_id_flush_o  output  1  IF/ID loads a NOP
- id_ex_hold_o  output  1  ID/EX holds its contents
- id_ex_bubble_o  output  1  ID/EX loads zeroed control signals
- ex_mem_bubble_o  output  1  EX/MEM loads zeroed control signals
- stall_cycles_o  output  CNT_W  count of cycles with pc_write_o=0

## Operation
- State machine, two states: RUN and MD_BUSY. Reset state is RUN.
- Outputs are combinational from state and inputs. Only the state and the counter are registered.
- Default outputs: pc_write_o=1, if_id_write_o=1, all other control outputs 0.

Decisions in RUN, first match wins:
  1. **Mul/div start.** Condition: ID_EX_MulDiv=1.
     - md_start_o=1, pc_write_o=0, if_id_write_o=0, id_ex_hold_o=1, ex_mem_bubble_o=1.
     - Next state MD_BUSY.
  2. **Load-use.** Condition: ID_EX_MemRead=1, ID_EX_Rd!=0, and either (IF_ID_UseRs1 and Rs1==Rd) or (IF_ID_UseRs2 and Rs2==Rd).
     - pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1.
     - Stay in RUN. The stall lasts exactly one cycle because the load leaves EX.
  3. **Taken branch.** Condition: branch_taken_i=1.
     - if_id_flush_o=1. PC advances to the target (pc_write_o=1).
  4. Otherwise default outputs.
- If ID_EX_MulDiv and ID_EX_MemRead are both 1, the mul/div rule wins. The load rule is not evaluated.
- A taken branch during a load-use stall is suppressed (no flush). ID re-evaluates the branch next cycle with forwarded data.
- md_done_i is ignored in RUN, including the cycle md_start_o is high.

MD_BUSY:
- md_done_i=0: pc_write_o=0, if_id_write_o=0, id_ex_hold_o=1, ex_mem_bubble_o=1, md_start_o=0. branch_taken_i is ignored and load-use is not evaluated.
- md_done_i=1: default outputs, so the result latches into EX/MEM and the pipeline advances. Next state RUN.
- A branch/load-use condition present in that same cycle is not acted on. It is re-evaluated in RUN next cycle.

Counter (stall_cycles_o):
- Increments by 1 on each clock edge where pc_write_o=0.
- Saturates at 2^CNT_W-1 and never wraps.

Reset, asynchronous, at any time including mid-MD_BUSY:
- State goes to RUN and stall_cycles_o to 0.
- The mul/div unit is reset by the same rst_i. No abort pulse is generated.

## Timing
- Reset values with all inputs 0: pc_write_o=1, if_id_write_o=1; md_start_o, if_id_flush_o, id_ex_hold_o, id_ex_bubble_o, ex_mem_bubble_o all 0; stall_cycles_o=0.
- Load-use penalty: 1 cycle.
- Taken-branch penalty: 1 flushed slot, no stall.
- Mul/div penalty: 1 start cycle plus the N MD_BUSY cycles before md_done_i, where N≥0 counts only MD_BUSY cycles with md_done_i=0.
- md_start_o is high for exactly one cycle per mul/div instruction. It is never reasserted while in MD_BUSY.
- Once the mul/div instruction has left EX on the done cycle, a new mul/div arriving in EX may start on the very next cycle.

## Test plan
- **Load-use.** ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5, UseRs2=1 for one cycle -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 for that cycle; stall_cycles_o goes 0->1.
- **No false stall.** Same as the load-use case but UseRs2=0 (or Rd=0) -> default outputs, counter unchanged.
- **Mul/div.** ID_EX_MulDiv=1 with md_done_i asserted 3 cycles after start:
  - Start cycle: md_start_o=1.
  - MD_BUSY cycles 1–2 (md_done_i=0): hold and bubble outputs high.
  - Done cycle: default outputs, next state RUN.
  - stall_cycles_o ends at 3.
- **Branch versus stalls.**
  - branch_taken_i=1 alone -> if_id_flush_o=1, pc_write_o=1.
  - branch_taken_i with load-use -> if_id_flush_o=0.
  - branch_taken_i during MD_BUSY -> ignored.
- **Reset mid-operation.** Assert rst_i asynchronously in MD_BUSY -> outputs return to reset values immediately, counter=0, and the next ID_EX_MulDiv produces a fresh md_start_o.
- **Saturation.** CNT_W=4 with 20 stall cycles -> stall_cycles_o holds at 15.
